// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);
    localparam int FIX_W         = 64;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    // Conditional two's-complement negation; callers zero-extend into and truncate out of FIX_W.
    function automatic logic [FIX_W-1:0] sign_fix(input logic [FIX_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/result bundle between the control unit (master) and the mult/div unit (slave).
interface mult_div_if import mult_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_restoring_step.sv
// One combinational iteration of unsigned restoring division (shift, trial subtract, restore).
module div_restoring_step import mult_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_bit;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        // rem < divisor always holds, so a successful trial fits back into WIDTH bits.
        if (trial[WIDTH+1]) begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed Booth multiply / restoring divide with HI/LO result registers.
// Optional feature macro: DIV_ZERO_EXC_EN (divide-by-zero short-circuits with div_zero flag).
module mult_div_unit import mult_div_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    mult_div_if.slave bus
);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int ACC_W = 2 * WIDTH + 2;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [WIDTH:0]   mcand_reg;
    logic [WIDTH-1:0] rem_reg, quo_reg, divisor_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             busy_reg, done_reg, div_zero_reg;

    logic [WIDTH:0]   booth_sum;
    logic [ACC_W-1:0] booth_next;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic [WIDTH-1:0] abs_a, abs_b, quo_fixed, rem_fixed;
    logic             last_iter;

    // The high partial product carries one guard bit: subtracting -2^(WIDTH-1) would overflow WIDTH bits.
    always_comb begin
        case (acc_reg[1:0])
            2'b01:   booth_sum = acc_reg[ACC_W-1:WIDTH+1] + mcand_reg;
            2'b10:   booth_sum = acc_reg[ACC_W-1:WIDTH+1] - mcand_reg;
            default: booth_sum = acc_reg[ACC_W-1:WIDTH+1];
        endcase
        booth_next = $signed({booth_sum, acc_reg[WIDTH:0]}) >>> 1;
    end

    assign abs_a     = WIDTH'(sign_fix(FIX_W'(bus.a), bus.a[WIDTH-1]));
    assign abs_b     = WIDTH'(sign_fix(FIX_W'(bus.b), bus.b[WIDTH-1]));
    assign quo_fixed = WIDTH'(sign_fix(FIX_W'(quo_next), neg_q_reg));
    assign rem_fixed = WIDTH'(sign_fix(FIX_W'(rem_next), neg_r_reg));
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (divisor_reg),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start_mult) begin
                        mcand_reg <= {bus.a[WIDTH-1], bus.a};
                        acc_reg   <= {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= MULT;
                    end else if (bus.start_div) begin
`ifdef DIV_ZERO_EXC_EN
                        if (bus.b == '0) begin
                            done_reg     <= 1'b1;
                            div_zero_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else
`endif
                        begin
                            rem_reg     <= '0;
                            quo_reg     <= abs_a;
                            divisor_reg <= abs_b;
                            neg_q_reg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            neg_r_reg   <= bus.a[WIDTH-1];
                            cnt_reg     <= '0;
                            busy_reg    <= 1'b1;
                            state_reg   <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc_reg <= booth_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        hi_reg    <= booth_next[2*WIDTH:WIDTH+1];
                        lo_reg    <= booth_next[WIDTH:1];
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        hi_reg    <= rem_fixed;
                        lo_reg    <= quo_fixed;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg     <= 1'b0;
                    div_zero_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;

endmodule
